// File: rtl/pipe_stage_skid_reg_pkg.sv
// ============================================================================
// Module  : pipe_pkg
// Purpose : Shared defaults and entry type for the pipeline stage registers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int unsigned       PIPE_XLEN        = 32;
    localparam int unsigned       PIPE_SIDE_W      = 8;
    localparam int unsigned       PIPE_CNT_W       = 16;
    localparam logic [31:0]       PIPE_BUBBLE_INST = 32'h0000_0033; // add x0,x0,x0

    typedef struct packed {
        logic [PIPE_XLEN-1:0]   inst;
        logic [PIPE_XLEN-1:0]   pc;
        logic [PIPE_SIDE_W-1:0] side;
    } pipe_entry_t;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_skid_reg_sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Purpose : Up-counter that sticks at all-ones; synchronous clear wins.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid_reg.sv
// ============================================================================
// Module  : pipe_stage_skid_reg
// Purpose : Valid/ready pipeline register with one-entry skid, flush-to-bubble,
//           external stall and saturating stall/flush counters.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      XLEN        = PIPE_XLEN,
    parameter int unsigned      SIDE_W      = PIPE_SIDE_W,
    parameter logic [XLEN-1:0]  BUBBLE_INST = XLEN'(PIPE_BUBBLE_INST),
    parameter int unsigned      CNT_W       = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              cnt_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_inst,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_inst,
    output logic [XLEN-1:0]   out_pc,
    output logic [SIDE_W-1:0] out_side,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic [XLEN-1:0]   inst;
        logic [XLEN-1:0]   pc;
        logic [SIDE_W-1:0] side;
    } entry_t;

    entry_t out_q,       out_d;
    entry_t skid_q,      skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q;

    entry_t w_in;
    logic   w_accept;
    logic   w_drain;
    logic   w_out_free;

    assign w_in       = '{inst: in_inst, pc: in_pc, side: in_side};
    assign w_accept   = in_valid & in_ready_q;
    assign w_drain    = out_valid_q & out_ready & ~stall;
    assign w_out_free = ~out_valid_q | w_drain;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            out_d        = '{inst: BUBBLE_INST, pc: '0, side: '0};
            skid_valid_d = 1'b0;
        end else if (w_out_free) begin
            if (skid_valid_q) begin
                out_d       = skid_q;
                out_valid_d = 1'b1;
                if (w_accept) begin
                    skid_d = w_in;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (w_accept) begin
                out_d       = w_in;
                out_valid_d = 1'b1;
            end else begin
                // Bubble keeps the last PC/sideband for debug visibility.
                out_valid_d = 1'b0;
                out_d.inst  = BUBBLE_INST;
            end
        end else if (w_accept) begin
            skid_d       = w_in;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '{inst: BUBBLE_INST, pc: '0, side: '0};
            out_valid_q  <= 1'b0;
            skid_q       <= '{inst: BUBBLE_INST, pc: '0, side: '0};
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= ~skid_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_inst  = out_q.inst;
    assign out_pc    = out_q.pc;
    assign out_side  = out_q.side;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst | cnt_clr),
        .inc   (~flush & out_valid_q & ~w_drain),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (rst | cnt_clr),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
// ============================================================================
// Module  : tb_pipe_stage_skid_reg
// Purpose : Directed self-checking bench for pipe_stage_skid_reg.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid_reg;

    logic        clk = 1'b0;
    logic        rst, flush, stall, cnt_clr, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;
    logic [7:0]  in_side;
    logic        in_ready, out_valid;
    logic [31:0] out_inst, out_pc;
    logic [7:0]  out_side;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_in_valid, s_out_ready, s_flush, s_stall, s_clr;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_inst, s_out_pc;
    logic [7:0]  s_out_side;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_reg u_dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .in_side(in_side),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_side(out_side),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter copy held permanently blocked to exercise saturation.
    pipe_stage_skid_reg #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .flush(s_flush), .stall(s_stall), .cnt_clr(s_clr),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_inst(32'h0000_0013), .in_pc(32'h0000_0100), .in_side(8'h01),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_inst(s_out_inst), .out_pc(s_out_pc), .out_side(s_out_side),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_inst  = 32'h1000_0000 | pc;
        in_side  = pc[7:0] ^ 8'h5A;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_pc"},    out_pc, pc);
        chk({tag, "_inst"},  out_inst, 32'h1000_0000 | pc);
        chk({tag, "_side"},  {24'b0, out_side}, {24'b0, pc[7:0] ^ 8'h5A});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0);
        s_in_valid = 1'b1; s_out_ready = 1'b0; s_flush = 1'b0; s_stall = 1'b0; s_clr = 1'b0;

        // Reset then idle
        tick(); tick();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_inst",  out_inst, 32'h0000_0033);
        chk("rst_pc",    out_pc, 32'd0);
        chk("rst_side",  {24'b0, out_side}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_scnt",  {16'b0, stall_cnt}, 32'd0);
        chk("rst_fcnt",  {16'b0, flush_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_valid", {31'b0, out_valid}, 32'd0);

        // Streaming: each entry visible one edge after acceptance
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i * 4));
            tick();
            chk_out("stream", 32'(i * 4));
            chk("stream_ready", {31'b0, in_ready}, 32'd1);
        end
        drive(1'b0, 32'h0);
        tick();
        chk("stream_end_valid", {31'b0, out_valid}, 32'd0);
        chk("stream_end_inst",  out_inst, 32'h0000_0033);
        chk("stream_end_pc",    out_pc, 32'h1C);
        chk("stream_scnt",      {16'b0, stall_cnt}, 32'd0);

        // Backpressure: one entry lands in the skid, then in_ready drops
        out_ready = 1'b0;
        drive(1'b1, 32'h40); tick();
        chk_out("bp_load", 32'h40);
        drive(1'b1, 32'h44); tick();
        chk("bp_ready_low", {31'b0, in_ready}, 32'd0);
        chk_out("bp_hold1", 32'h40);
        drive(1'b1, 32'h48); tick();
        tick();
        chk_out("bp_hold3", 32'h40);
        chk("bp_scnt", {16'b0, stall_cnt}, 32'd3);
        out_ready = 1'b1;
        tick();
        chk_out("bp_rel_skid", 32'h44);
        chk("bp_rel_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk_out("bp_rel_next", 32'h48);
        drive(1'b0, 32'h0); tick();
        chk("bp_empty", {31'b0, out_valid}, 32'd0);
        chk("bp_scnt_final", {16'b0, stall_cnt}, 32'd3);

        // Flush with full skid
        out_ready = 1'b0;
        drive(1'b1, 32'h80); tick();
        drive(1'b1, 32'h84); tick();
        chk("fl_skid_full", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 32'h88); flush = 1'b1; tick();
        flush = 1'b0;
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_inst",  out_inst, 32'h0000_0033);
        chk("fl_pc",    out_pc, 32'd0);
        chk("fl_side",  {24'b0, out_side}, 32'd0);
        chk("fl_ready", {31'b0, in_ready}, 32'd1);
        chk("fl_fcnt",  {16'b0, flush_cnt}, 32'd1);
        chk("fl_scnt",  {16'b0, stall_cnt}, 32'd4);
        out_ready = 1'b1;
        drive(1'b0, 32'h0); tick();
        chk("fl_no_skid", {31'b0, out_valid}, 32'd0);
        // Entry accepted in the flush cycle is discarded
        drive(1'b1, 32'h8C); flush = 1'b1; tick();
        flush = 1'b0;
        drive(1'b0, 32'h0); tick();
        chk("fl_drop_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_fcnt2", {16'b0, flush_cnt}, 32'd2);
        // Simultaneous flush and clear: clear wins
        flush = 1'b1; cnt_clr = 1'b1; tick();
        flush = 1'b0; cnt_clr = 1'b0;
        chk("clr_fcnt", {16'b0, flush_cnt}, 32'd0);
        chk("clr_scnt", {16'b0, stall_cnt}, 32'd0);

        // External stall holds the output even with out_ready high
        drive(1'b1, 32'hC0); tick();
        chk_out("st_load", 32'hC0);
        stall = 1'b1;
        drive(1'b1, 32'hC4); tick();
        chk_out("st_hold1", 32'hC0);
        chk("st_ready_low", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 32'hC8); tick();
        chk_out("st_hold2", 32'hC0);
        chk("st_scnt", {16'b0, stall_cnt}, 32'd2);
        stall = 1'b0; tick();
        chk_out("st_rel_skid", 32'hC4);
        tick();
        chk_out("st_rel_next", 32'hC8);
        drive(1'b0, 32'h0); tick();
        chk("st_empty", {31'b0, out_valid}, 32'd0);
        chk("st_scnt_final", {16'b0, stall_cnt}, 32'd2);

        // Saturation on the 4-bit copy, blocked since reset release
        chk("sat_max", {28'b0, s_stall_cnt}, 32'd15);
        s_clr = 1'b1; tick();
        s_clr = 1'b0;
        chk("sat_clr", {28'b0, s_stall_cnt}, 32'd0);
        tick();
        chk("sat_restart", {28'b0, s_stall_cnt}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
